chu_msg_src: RTL

- Transmit end of the chu_pad byte-stream interface (sys_clk, sys_reset, sop, val, data, eop, alg).
- A host or bench pushes message bytes into an internal FIFO; the block replays them towards chu_pad as framed messages.
- Framing rules: sop on the first byte, eop on the last byte, alg held for the whole message, enforced inter-message gap.
- Also counts sent messages, so the count can be checked against chu_pad's mes_cnt.

---
 rtl/chu_pkg.sv | 28 ++
 rtl/chu_src_fifo.sv | 66 ++++++
 rtl/chu_msg_src.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/chu_pkg.sv
// rtl/chu_pkg.sv - shared types and constants for the chu_pad message source
package chu_pkg;

    typedef enum logic [1:0] {
        ALG_MD5    = 2'd0,
        ALG_SHA1   = 2'd1,
        ALG_SHA256 = 2'd2
    } chu_alg_t;

    localparam int CHU_DATA_W  = 8;
    localparam int CHU_MAX_LEN = 55;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        DRAIN,
        GAP
    } chu_src_state_t;

    typedef struct packed {
        chu_alg_t              alg;
        logic                  last;
        logic [CHU_DATA_W-1:0] data;
    } chu_src_entry_t;

    localparam int CHU_ENTRY_W = $bits(chu_src_entry_t);

endpackage

// File: rtl/chu_src_fifo.sv
// rtl/chu_src_fifo.sv - synchronous FIFO; a push while full is taken only if a pop frees a slot
module chu_src_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] CNT_FULL = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             push_ok, pop_ok;

    assign full  = (count_q == CNT_FULL);
    assign empty = (count_q == '0);
    assign head  = mem_q[rd_ptr_q];

    always_comb begin
        pop_ok   = pop && !empty;
        push_ok  = push && (!full || pop_ok);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push_ok && !pop_ok) begin
            count_d = count_q + 1'b1;
        end else if (!push_ok && pop_ok) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: empty/full come from the counter alone.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/chu_msg_src.sv
// rtl/chu_msg_src.sv - replays pushed bytes to chu_pad as framed messages and counts them
module chu_msg_src #(
    parameter int DEPTH   = 16,
    parameter int MAX_LEN = 55,
    parameter int IFG     = 2,
    parameter int CNT_W   = 8
) (
    input  logic             sys_clk,
    input  logic             sys_reset,
    input  logic             wr_en,
    input  logic [7:0]       wr_data,
    input  logic             wr_last,
    input  logic [1:0]       wr_alg,
    output logic             full,
    input  logic             rdy,
    output logic             sop,
    output logic             val,
    output logic [7:0]       data,
    output logic             eop,
    output logic [1:0]       alg,
    output logic [CNT_W-1:0] tx_cnt,
    output logic             err_len
);
    import chu_pkg::*;

    chu_src_entry_t             wr_entry, head;
    logic [CHU_ENTRY_W-1:0]     head_raw;
    logic                       fifo_pop, fifo_empty;

    chu_src_state_t             state_q, state_d;
    logic [2:0]                 gap_q, gap_d;
    logic [5:0]                 len_q, len_d, len_nxt;
    logic                       held_q, held_d;
    logic                       val_q, val_d, sop_q, sop_d, eop_q, eop_d;
    logic [7:0]                 data_q, data_d;
    logic [1:0]                 alg_q, alg_d;
    logic [CNT_W-1:0]           tx_cnt_q, tx_cnt_d;
    logic                       err_q, err_d;
    logic                       issue, end_msg, resend, out_free, hit_max;

    assign wr_entry.alg  = chu_alg_t'(wr_alg);
    assign wr_entry.last = wr_last;
    assign wr_entry.data = wr_data;
    assign head          = chu_src_entry_t'(head_raw);

    chu_src_fifo #(
        .DEPTH(DEPTH),
        .WIDTH(CHU_ENTRY_W)
    ) u_fifo (
        .clk      (sys_clk),
        .rst      (sys_reset),
        .push     (wr_en),
        .push_data(wr_entry),
        .pop      (fifo_pop),
        .head     (head_raw),
        .full     (full),
        .empty    (fifo_empty)
    );

    always_comb begin
        state_d  = state_q;
        gap_d    = gap_q;
        len_d    = len_q;
        val_d    = 1'b0;
        sop_d    = sop_q;
        eop_d    = eop_q;
        data_d   = data_q;
        alg_d    = alg_q;
        err_d    = err_q;
        fifo_pop = 1'b0;
        issue    = 1'b0;
        end_msg  = 1'b0;
        tx_cnt_d = tx_cnt_q + CNT_W'(val_q && rdy && eop_q);

        // A presented byte refused by rdy=0 stays in the output register and is replayed.
        held_d   = val_q ? !rdy : held_q;
        resend   = !val_q && held_q && rdy;
        out_free = rdy && !(!val_q && held_q);
        len_nxt  = (state_q == IDLE) ? 6'd1 : len_q + 6'd1;
        hit_max  = (len_nxt == 6'(MAX_LEN));

        if (resend) begin
            val_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                len_d = '0;
                if (out_free && !fifo_empty && gap_q == '0) begin
                    issue = 1'b1;
                end
            end
            SEND: begin
                if (out_free && !fifo_empty) begin
                    issue = 1'b1;
                end
            end
            DRAIN: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    end_msg  = head.last;
                end
            end
            GAP: begin
                // The gap only runs once the eop byte has actually been taken.
                if (!held_d) begin
                    if (gap_q <= 3'd1) begin
                        gap_d   = '0;
                        state_d = IDLE;
                    end else begin
                        gap_d = gap_q - 3'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (issue) begin
            fifo_pop = 1'b1;
            val_d    = 1'b1;
            data_d   = head.data;
            len_d    = len_nxt;
            sop_d    = (state_q == IDLE);
            eop_d    = head.last || hit_max;
            if (state_q == IDLE) begin
                alg_d = head.alg;
            end
            if (head.last) begin
                end_msg = 1'b1;
            end else if (hit_max) begin
                err_d   = 1'b1;
                state_d = DRAIN;
            end else begin
                state_d = SEND;
            end
        end

        if (end_msg) begin
            gap_d   = 3'(IFG);
            state_d = (IFG == 0) ? IDLE : GAP;
        end
    end

    always_ff @(posedge sys_clk or posedge sys_reset) begin
        if (sys_reset) begin
            state_q  <= IDLE;
            gap_q    <= '0;
            len_q    <= '0;
            held_q   <= 1'b0;
            val_q    <= 1'b0;
            sop_q    <= 1'b0;
            eop_q    <= 1'b0;
            data_q   <= '0;
            alg_q    <= '0;
            tx_cnt_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            gap_q    <= gap_d;
            len_q    <= len_d;
            held_q   <= held_d;
            val_q    <= val_d;
            sop_q    <= sop_d;
            eop_q    <= eop_d;
            data_q   <= data_d;
            alg_q    <= alg_d;
            tx_cnt_q <= tx_cnt_d;
            err_q    <= err_d;
        end
    end

    assign sop     = sop_q;
    assign val     = val_q;
    assign data    = data_q;
    assign eop     = eop_q;
    assign alg     = alg_q;
    assign tx_cnt  = tx_cnt_q;
    assign err_len = err_q;

endmodule
